// File: rtl/mux_pkg.sv
// Shared types and constants for the 16-way registered select stage.
package mux_pkg;
  localparam int DATA_W = 16;
  typedef logic [3:0]        sel_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/mux16_1_registered_mux4.sv
// Purpose: combinational 4:1 word select on a 2-bit code.
// Latency: none, pure combinational.
// Backpressure: none; output follows inputs continuously.
module mux4_1 #(
  parameter int WIDTH = mux_pkg::DATA_W
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end
endmodule

// File: rtl/mux16_1_registered.sv
// Purpose: 16-way word select feeding an output register qualified by in_valid.
// Latency: 1 cycle from sample edge to out/out_valid.
// Backpressure: none; accepts one word per cycle, out holds while in_valid is low.
module mux16_1_registered
  import mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  input  logic [WIDTH-1:0] in10,
  input  logic [WIDTH-1:0] in11,
  input  logic [WIDTH-1:0] in12,
  input  logic [WIDTH-1:0] in13,
  input  logic [WIDTH-1:0] in14,
  input  logic [WIDTH-1:0] in15,
  input  sel_t             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);
  logic [WIDTH-1:0] grp0, grp1, grp2, grp3, sel_word;

  // First rank picks within each group of four on sel[1:0]; second rank picks the group.
  mux4_1 #(.WIDTH(WIDTH)) u_grp0 (.d0(in0),  .d1(in1),  .d2(in2),  .d3(in3),  .sel(sel[1:0]), .y(grp0));
  mux4_1 #(.WIDTH(WIDTH)) u_grp1 (.d0(in4),  .d1(in5),  .d2(in6),  .d3(in7),  .sel(sel[1:0]), .y(grp1));
  mux4_1 #(.WIDTH(WIDTH)) u_grp2 (.d0(in8),  .d1(in9),  .d2(in10), .d3(in11), .sel(sel[1:0]), .y(grp2));
  mux4_1 #(.WIDTH(WIDTH)) u_grp3 (.d0(in12), .d1(in13), .d2(in14), .d3(in15), .sel(sel[1:0]), .y(grp3));
  mux4_1 #(.WIDTH(WIDTH)) u_final (.d0(grp0), .d1(grp1), .d2(grp2), .d3(grp3), .sel(sel[3:2]), .y(sel_word));

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= sel_word;
    end
  end
endmodule

// File: tb/tb_mux16_1_registered.sv
// Directed bench for the registered 16:1 select stage; inputs change 1ns after
// each rising edge and outputs are checked at that same point.
module tb_mux16_1_registered;
  import mux_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  data_t din [16];
  sel_t  sel;
  logic  in_valid;
  data_t out;
  logic  out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux16_1_registered #(.WIDTH(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in0(din[0]),   .in1(din[1]),   .in2(din[2]),   .in3(din[3]),
    .in4(din[4]),   .in5(din[5]),   .in6(din[6]),   .in7(din[7]),
    .in8(din[8]),   .in9(din[9]),   .in10(din[10]), .in11(din[11]),
    .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .sel(sel), .in_valid(in_valid), .out(out), .out_valid(out_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input data_t obs, input data_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input data_t exp_out, input logic exp_vld);
    chk({tag, ".out"}, out, exp_out);
    chk({tag, ".vld"}, {15'd0, out_valid}, {15'd0, exp_vld});
  endtask

  task automatic fill(input data_t v);
    for (int i = 0; i < 16; i++) din[i] = v;
  endtask

  initial begin
    data_t exp_w;

    // Reset held two cycles while a capture is being offered.
    fill(16'h0000);
    din[5]   = 16'hBEEF;
    sel      = 4'd5;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    chk_out("rst_c1", 16'h0000, 1'b0);
    tick();
    chk_out("rst_c2", 16'h0000, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_out("rst_post", 16'h0000, 1'b0);

    // Exhaustive sweep, back-to-back.
    for (int n = 0; n < 16; n++) din[n] = 16'h1000 + 16'(n);
    in_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel = sel_t'(s);
      tick();
      chk_out($sformatf("sweep%0d", s), 16'h1000 + 16'(s), 1'b1);
    end

    // Random data with walking select.
    for (int s = 0; s < 16; s++) begin
      for (int n = 0; n < 16; n++) din[n] = data_t'($urandom);
      sel   = sel_t'(s);
      exp_w = din[s];
      tick();
      chk_out($sformatf("rand%0d", s), exp_w, 1'b1);
    end

    // Hold: capture then change sel/data with in_valid low.
    sel    = 4'd3;
    din[3] = 16'hA5A5;
    tick();
    chk_out("hold_cap", 16'hA5A5, 1'b1);
    in_valid = 1'b0;
    sel      = 4'd9;
    din[3]   = 16'h0000;
    tick();
    chk_out("hold1", 16'hA5A5, 1'b0);
    tick();
    chk_out("hold2", 16'hA5A5, 1'b0);

    // Reset mid-stream at sel=7.
    for (int n = 0; n < 16; n++) din[n] = 16'h1000 + 16'(n);
    in_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel = sel_t'(s);
      rst = (s == 7);
      tick();
      if (s == 7) chk_out("midrst", 16'h0000, 1'b0);
      else        chk_out($sformatf("resume%0d", s), 16'h1000 + 16'(s), 1'b1);
    end
    rst = 1'b0;

    // Boundary select codes.
    fill(16'h0000);
    din[0] = 16'hFFFF;
    sel    = 4'd0;
    tick();
    chk_out("bound_sel0", 16'hFFFF, 1'b1);
    fill(16'hFFFF);
    din[15] = 16'h8001;
    sel     = 4'd15;
    tick();
    chk_out("bound_sel15", 16'h8001, 1'b1);
    in_valid = 1'b0;
    tick();
    chk_out("bound_idle", 16'h8001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
